// File: rtl/bram_port_server.sv
// bram_port_server: request/response front end for one port of a
// byte-enabled, write-first BRAM (1- or 2-cycle read latency).
//
// Parameters: PIPELINED (0: DO valid 1 cycle after issue, 1: 2 cycles),
//   ADDR_WIDTH, DATA_WIDTH, WE_WIDTH, RSP_DEPTH (power of two, >= 2).
// Ports:
//   CLK, RST_N           clock, async active-low reset
//   REQ_EN/REQ_RDY       request handshake; REQ_WE all-zero = read
//   REQ_ADDR/REQ_DATA    request address / write data
//   RSP_VALID/RSP_DATA   response FIFO head
//   RSP_DEQ              pop FIFO head (ignored when empty)
//   BRAM_EN/WE/ADDR/DI   driven to the BRAM port
//   BRAM_DO              read data from the BRAM port
//   BUSY                 reads in flight or FIFO not empty
// Macro BRAM_SRV_WRITE_RSP_EN: when defined, writes also return a
//   response (the merged write-first word) and consume a credit.

module bram_port_server #(
   parameter int PIPELINED  = 0,
   parameter int ADDR_WIDTH = 1,
   parameter int DATA_WIDTH = 1,
   parameter int WE_WIDTH   = 1,
   parameter int RSP_DEPTH  = 4
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  REQ_EN,
   output logic                  REQ_RDY,
   input  logic [WE_WIDTH-1:0]   REQ_WE,
   input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
   input  logic [DATA_WIDTH-1:0] REQ_DATA,
   output logic                  RSP_VALID,
   output logic [DATA_WIDTH-1:0] RSP_DATA,
   input  logic                  RSP_DEQ,
   output logic                  BRAM_EN,
   output logic [WE_WIDTH-1:0]   BRAM_WE,
   output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
   output logic [DATA_WIDTH-1:0] BRAM_DI,
   input  logic [DATA_WIDTH-1:0] BRAM_DO,
   output logic                  BUSY
);

   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = PW + 1;
   localparam int NS = PIPELINED + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(RSP_DEPTH);

   logic [NS-1:0]         r_vpipe;
   logic [CW-1:0]         r_inflight;
   logic [CW-1:0]         r_fifo_cnt;
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];

   logic [NS:0]           w_vshift;
   logic [CW:0]           w_used;
   logic                  w_acc;
   logic                  w_rsp_gen;
   logic                  w_push;
   logic                  w_cap;
   logic                  w_pop;

   // Credits cover both in-flight reads and queued words, so every
   // capture is guaranteed a free FIFO slot.
   assign w_used  = {1'b0, r_inflight} + {1'b0, r_fifo_cnt};
   assign REQ_RDY = RST_N & (w_used < DEPTH_W);

   assign w_acc     = REQ_EN & REQ_RDY;
   assign BRAM_EN   = w_acc;
   assign BRAM_WE   = w_acc ? REQ_WE : '0;
   assign BRAM_ADDR = REQ_ADDR;
   assign BRAM_DI   = REQ_DATA;

`ifdef BRAM_SRV_WRITE_RSP_EN
   assign w_rsp_gen = 1'b1;
`else
   assign w_rsp_gen = (REQ_WE == '0);
`endif

   assign w_push    = w_acc & w_rsp_gen;
   assign w_vshift  = {r_vpipe, w_push};
   assign w_cap     = r_vpipe[NS-1];
   assign RSP_VALID = (r_fifo_cnt != '0);
   assign w_pop     = RSP_DEQ & RSP_VALID;
   assign RSP_DATA  = r_mem[r_rd_ptr];
   assign BUSY      = (r_inflight != '0) | RSP_VALID;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_vpipe    <= '0;
         r_inflight <= '0;
         r_fifo_cnt <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         r_vpipe <= w_vshift[NS-1:0];
         unique case ({w_push, w_cap})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase
         unique case ({w_cap, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
            2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
         if (w_cap) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   // Storage needs no reset: visibility is governed by r_fifo_cnt.
   always_ff @(posedge CLK) begin
      if (w_cap) r_mem[r_wr_ptr] <= BRAM_DO;
   end

endmodule

// File: tb/tb_bram_port_server.sv
// tb_bram_port_server: directed bench driving a PIPELINED=0 and a
// PIPELINED=1 instance in lockstep, each with its own BRAM model.

module tb_bram_port_server;

`ifdef BRAM_SRV_WRITE_RSP_EN
   localparam bit WRSP = 1'b1;
`else
   localparam bit WRSP = 1'b0;
`endif

   logic        clk;
   logic        RST_N;
   logic        REQ_EN;
   logic [3:0]  REQ_WE;
   logic [3:0]  REQ_ADDR;
   logic [31:0] REQ_DATA;
   logic        RSP_DEQ;

   logic        rdy     [2];
   logic        rspv    [2];
   logic [31:0] rspd    [2];
   logic        bram_en [2];
   logic [3:0]  bram_we [2];
   logic [3:0]  bram_ad [2];
   logic [31:0] bram_di [2];
   logic [31:0] bram_do [2];
   logic        busy    [2];

   int nvec;
   int nerr;
   int nacc  [2];
   int npop  [2];
   int outst [2];
   logic [31:0] got [2][32];
   logic [31:0] sexp [8];
   logic [31:0] bexp [4];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] di,
                                         input logic [3:0]  we);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (we[b]) r[8*b +: 8] = di[8*b +: 8];
      return r;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      logic [31:0] mem [16];
      logic [31:0] do1;
      logic [31:0] do2;
      logic [31:0] m;

      initial
         for (int a = 0; a < 16; a++) mem[a] = 32'hA000_0000 + 32'(a);

      always @(posedge clk) begin
         if (bram_en[g]) begin
            m = merge(mem[bram_ad[g]], bram_di[g], bram_we[g]);
            mem[bram_ad[g]] = m;
            do1 <= m;
         end
         do2 <= do1;
      end

      assign bram_do[g] = (g == 0) ? do1 : do2;

      bram_port_server #(
         .PIPELINED(g), .ADDR_WIDTH(4), .DATA_WIDTH(32),
         .WE_WIDTH(4), .RSP_DEPTH(4)
      ) u_dut (
         .CLK(clk), .RST_N(RST_N),
         .REQ_EN(REQ_EN), .REQ_RDY(rdy[g]),
         .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
         .RSP_VALID(rspv[g]), .RSP_DATA(rspd[g]), .RSP_DEQ(RSP_DEQ),
         .BRAM_EN(bram_en[g]), .BRAM_WE(bram_we[g]),
         .BRAM_ADDR(bram_ad[g]), .BRAM_DI(bram_di[g]),
         .BRAM_DO(bram_do[g]), .BUSY(busy[g])
      );
   end

   task automatic chk(input string tag, input int i,
                      input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s[P%0d]: got %h want %h", tag, i, obs, exp);
      end
   endtask

   // One clock: observe handshakes mid-cycle, update the credit model,
   // then step to just after the next rising edge.
   task automatic cyc();
      logic a;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         a = REQ_EN & rdy[i];
         if (a) nacc[i]++;
         if (a && (REQ_WE == 4'h0 || WRSP)) outst[i]++;
         if (RSP_DEQ && rspv[i]) begin
            if (npop[i] < 32) got[i][npop[i]] = rspd[i];
            npop[i]++;
            outst[i]--;
         end
         chk("credit_inv", i, 32'(outst[i] <= 4), 32'd1);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      for (int i = 0; i < 2; i++) begin
         nacc[i] = 0; npop[i] = 0; outst[i] = 0;
      end
      for (int k = 0; k < 8; k++) sexp[k] = 32'hA000_0000 + 32'(k);
      sexp[3] = 32'hDE22_BE44;
      bexp[0] = 32'hA000_0000;
      bexp[1] = 32'hA000_0001;
      bexp[2] = 32'hA000_0002;
      bexp[3] = 32'hDE22_BE44;

      RST_N = 1'b0; REQ_EN = 1'b1; REQ_WE = 4'h0;
      REQ_ADDR = 4'h0; REQ_DATA = 32'h0; RSP_DEQ = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_rdy", i, 32'(rdy[i]), 32'd0);
         chk("rst_rspv", i, 32'(rspv[i]), 32'd0);
         chk("rst_busy", i, 32'(busy[i]), 32'd0);
         chk("rst_en", i, 32'(bram_en[i]), 32'd0);
      end
      repeat (2) cyc();
      RST_N = 1'b1; REQ_EN = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) chk("rel_rdy", i, 32'(rdy[i]), 32'd1);

      // full-word write, drain any write response, then read back
      REQ_EN = 1'b1; REQ_WE = 4'hF; REQ_ADDR = 4'd3;
      REQ_DATA = 32'hDEAD_BEEF; RSP_DEQ = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("wr_en", i, 32'(bram_en[i]), 32'd1);
         chk("wr_we", i, 32'(bram_we[i]), 32'hF);
         chk("wr_di", i, bram_di[i], 32'hDEAD_BEEF);
      end
      cyc();
      REQ_EN = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) chk("idle_we", i, 32'(bram_we[i]), 32'h0);
      repeat (4) cyc();
      REQ_WE = 4'h0; REQ_EN = 1'b1;
      cyc();
      REQ_EN = 1'b0;
      for (int i = 0; i < 2; i++) chk("rt_v1", i, 32'(rspv[i]), 32'd0);
      cyc();
      chk("rt_v2", 0, 32'(rspv[0]), 32'd1);
      chk("rt_d2", 0, rspd[0], 32'hDEAD_BEEF);
      chk("rt_v2", 1, 32'(rspv[1]), 32'd0);
      cyc();
      chk("rt_v3", 0, 32'(rspv[0]), 32'd0);
      chk("rt_v3", 1, 32'(rspv[1]), 32'd1);
      chk("rt_d3", 1, rspd[1], 32'hDEAD_BEEF);
      cyc();
      RSP_DEQ = 1'b0;

      // byte-enable write immediately followed by a read
      REQ_EN = 1'b1; REQ_WE = 4'b0101; REQ_DATA = 32'h1122_3344;
      cyc();
      REQ_WE = 4'h0;
      cyc();
      REQ_EN = 1'b0;
      repeat (4) cyc();
      for (int i = 0; i < 2; i++) begin
         chk("be_v", i, 32'(rspv[i]), 32'd1);
         chk("be_d", i, rspd[i], 32'hDE22_BE44);
      end
      RSP_DEQ = 1'b1;
      cyc();
      RSP_DEQ = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("wrsp_v", i, 32'(rspv[i]), 32'(WRSP));
         if (WRSP) chk("wrsp_d", i, rspd[i], 32'hDE22_BE44);
      end
      RSP_DEQ = WRSP;
      cyc();
      RSP_DEQ = 1'b0;
      for (int i = 0; i < 2; i++) chk("be_busy", i, 32'(busy[i]), 32'd0);

      // backpressure: six reads, no pops
      for (int i = 0; i < 2; i++) nacc[i] = 0;
      REQ_EN = 1'b1;
      for (int k = 0; k < 6; k++) begin
         REQ_ADDR = 4'(k);
         cyc();
      end
      REQ_EN = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("bp_acc", i, 32'(nacc[i]), 32'd4);
         chk("bp_rdy", i, 32'(rdy[i]), 32'd0);
      end
      repeat (3) cyc();
      for (int i = 0; i < 2; i++) chk("bp_d0", i, rspd[i], bexp[0]);
      RSP_DEQ = 1'b1;
      cyc();
      RSP_DEQ = 1'b0;
      for (int i = 0; i < 2; i++) chk("bp_rdy_up", i, 32'(rdy[i]), 32'd1);
      for (int k = 1; k < 4; k++) begin
         for (int i = 0; i < 2; i++) chk("bp_dn", i, rspd[i], bexp[k]);
         RSP_DEQ = 1'b1;
         cyc();
         RSP_DEQ = 1'b0;
      end
      for (int i = 0; i < 2; i++) chk("bp_empty", i, 32'(rspv[i]), 32'd0);

      // three reads then a write: only a responding write takes the last credit
      REQ_EN = 1'b1;
      for (int k = 0; k < 3; k++) begin
         REQ_ADDR = 4'(k);
         cyc();
      end
      REQ_WE = 4'hF; REQ_ADDR = 4'd8; REQ_DATA = 32'h0000_0055;
      cyc();
      REQ_EN = 1'b0; REQ_WE = 4'h0;
      for (int i = 0; i < 2; i++) chk("wcred_rdy", i, 32'(rdy[i]), 32'(!WRSP));
      RSP_DEQ = 1'b1;
      repeat (8) cyc();
      RSP_DEQ = 1'b0;
      for (int i = 0; i < 2; i++) chk("wcred_busy", i, 32'(busy[i]), 32'd0);

      // streaming reads with the consumer always ready
      for (int i = 0; i < 2; i++) npop[i] = 0;
      RSP_DEQ = 1'b1; REQ_EN = 1'b1;
      for (int k = 0; k < 8; k++) begin
         REQ_ADDR = 4'(k);
         for (int i = 0; i < 2; i++) chk("st_rdy", i, 32'(rdy[i]), 32'd1);
         cyc();
      end
      REQ_EN = 1'b0;
      repeat (6) cyc();
      RSP_DEQ = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("st_cnt", i, 32'(npop[i]), 32'd8);
         for (int k = 0; k < 8; k++) chk("st_data", i, got[i][k], sexp[k]);
      end

      // reset with three reads in flight
      REQ_EN = 1'b1;
      for (int k = 4; k < 7; k++) begin
         REQ_ADDR = 4'(k);
         cyc();
      end
      REQ_EN = 1'b0;
      RST_N = 1'b0;
      for (int i = 0; i < 2; i++) outst[i] = 0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("mr_rspv", i, 32'(rspv[i]), 32'd0);
         chk("mr_busy", i, 32'(busy[i]), 32'd0);
         chk("mr_rdy", i, 32'(rdy[i]), 32'd0);
      end
      cyc();
      RST_N = 1'b1;
      repeat (5) cyc();
      for (int i = 0; i < 2; i++) begin
         chk("mr_stale", i, 32'(rspv[i]), 32'd0);
         chk("mr_idle", i, 32'(busy[i]), 32'd0);
      end
      REQ_EN = 1'b1; REQ_ADDR = 4'd3;
      cyc();
      REQ_EN = 1'b0;
      repeat (3) cyc();
      for (int i = 0; i < 2; i++) begin
         chk("mr_rd_v", i, 32'(rspv[i]), 32'd1);
         chk("mr_rd_d", i, rspd[i], 32'hDE22_BE44);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/bram_port_server.md
# bram_port_server

Request/response front end that drives one port of the team's byte-enabled, write-first dual-port BRAM (`BRAM2BE`-style port: EN/WE/ADDR/DI in, DO out).
- Accepts read/write requests on a ready/enable handshake and forwards them to the BRAM port in the same cycle.
- Tracks in-flight reads across the BRAM's 1- or 2-cycle read latency and captures returned words into an in-order response FIFO.
- Uses credit flow control so that no response is ever dropped.
- Sits between a bus-side client (DMA engine, control-plane target) and the memory instance.

## Interface
Parameters:
- PIPELINED, 0, must match the attached BRAM. 0: DO valid 1 cycle after issue; 1: DO valid 2 cycles after issue.
- ADDR_WIDTH, 1, BRAM address width.
- DATA_WIDTH, 1, BRAM word width.
- WE_WIDTH, 1, number of byte-enable lanes. DATA_WIDTH = WE_WIDTH*CHUNKSIZE.
- RSP_DEPTH, 4, response FIFO depth. Power of two, at least 2.

Ports:
- CLK  in  1  the block's single clock. BRAM port clock is the same clock.
- RST_N  in  1  reset, asynchronous and active-low.
- REQ_EN  in  1  request strobe. A request is accepted when REQ_EN & REQ_RDY.
- REQ_RDY  out  1  request may be accepted this cycle.
- REQ_WE  in  WE_WIDTH  per-lane write enables. All zero means a read.
- REQ_ADDR  in  ADDR_WIDTH  request address.
- REQ_DATA  in  DATA_WIDTH  write data.
- RSP_VALID  out  1  FIFO head holds a response.
- RSP_DATA  out  DATA_WIDTH  FIFO head data.
- RSP_DEQ  in  1  pop the FIFO head. Ignored when RSP_VALID=0.
- BRAM_EN  out  1  to BRAM EN.
- BRAM_WE  out  WE_WIDTH  to BRAM WE.
- BRAM_ADDR  out  ADDR_WIDTH  to BRAM ADDR.
- BRAM_DI  out  DATA_WIDTH  to BRAM DI.
- BRAM_DO  in  DATA_WIDTH  from BRAM DO.
- BUSY  out  1  in-flight count nonzero or FIFO nonempty.

## Operation
Issue path (combinational):
- acc = REQ_EN & REQ_RDY.
- BRAM_EN = acc.
- BRAM_WE = acc ? REQ_WE : 0.
- BRAM_ADDR = REQ_ADDR; BRAM_DI = REQ_DATA.

Response-generating request:
- Any read.
- A write, only when the configuration macro is defined.

Tracking pipeline:
- Valid shift register, 1+PIPELINED stages.
- Stage 0 loads "acc and response-generating".
- The last stage, when set, marks BRAM_DO valid that cycle. The block captures BRAM_DO into the FIFO tail on that edge.

Credit accounting:
- inflight: width $clog2(RSP_DEPTH)+1. Increments on a response-generating accept; decrements on capture.
- fifo_cnt: same width. Increments on capture; decrements on a pop (RSP_DEQ & RSP_VALID).
- Simultaneous increment and decrement on either counter leaves it unchanged.
- Invariant: inflight + fifo_cnt <= RSP_DEPTH. The bench must flag any violation.
- REQ_RDY = RST_N & (inflight + fifo_cnt < RSP_DEPTH). It is registered-state driven, with no combinational path from REQ_EN, REQ_WE or RSP_DEQ.
- REQ_RDY applies to both reads and writes.

FIFO and ordering:
- Circular buffer with rd/wr pointers that wrap modulo RSP_DEPTH.
- A capture and a pop in the same cycle, including at fifo_cnt = RSP_DEPTH, both take effect.
- Responses leave in request order. No bypass: a word is visible only after it is written into the FIFO.

Reset (RST_N low, at any time):
- Clears the valid pipe, inflight, fifo_cnt and pointers immediately.
- Outputs: REQ_RDY=0, RSP_VALID=0, BUSY=0, BRAM_EN=0, BRAM_WE=0.
- BRAM contents are untouched.
- Reads in flight at reset are discarded; no stale word appears after release.

## Timing
- Request accepted in cycle t → RSP_VALID high in cycle t+2+PIPELINED.
- Sustained throughput: one request per cycle whenever RSP_DEQ is held high.
- A pop at the edge ending cycle t frees a credit: REQ_RDY rises in cycle t+1.
- A write updates the BRAM at the edge ending its accept cycle. A read accepted the next cycle sees the new data.

## Configuration
Macro: BRAM_SRV_WRITE_RSP_EN.
- Defined:
  - Writes are response-generating and consume a credit.
  - The response is the merged write-first word the BRAM returns on DO.
- Undefined:
  - Writes consume no credit and produce no response.
  - The valid pipe ignores writes.
  - REQ_RDY still gates writes.

## Test plan
Setup: DATA_WIDTH=32, WE_WIDTH=4, ADDR_WIDTH=4, RSP_DEPTH=4. Run each scenario at PIPELINED=0 and at PIPELINED=1.
- Write/read round trip: write 0xDEADBEEF to addr 3 with WE=4'hF, then read addr 3 → RSP_DATA=0xDEADBEEF in cycle accept+2 (PIPELINED=0) or accept+3 (PIPELINED=1).
- Byte enables: write 0x11223344 with WE=4'b0101 over 0xDEADBEEF at addr 3, then read → 0xDE22BE44.
- Backpressure: RSP_DEQ=0, 6 back-to-back reads → exactly 4 accepted and REQ_RDY=0 after the 4th; one pop → REQ_RDY=1 the next cycle; remaining data in order.
- Streaming: reads of addr 0..7 back to back with RSP_DEQ=1 → REQ_RDY never drops; 8 responses in address order; FIFO pointers wrap.
- Reset mid-operation: 3 reads in flight, RST_N low for 1 cycle → RSP_VALID=0, BUSY=0 and REQ_RDY=0 immediately; no response after release; BRAM data still readable.
- Write response (macro defined/undefined), repeating the byte-enable write:
  - Defined: RSP_VALID with 0xDE22BE44, and the credit is consumed.
  - Undefined: no RSP_VALID and no credit change.
